elevator_controller: RTL
========================

ELEVATOR_CONTROLLER -- requirements
Module: elevator_controller

Interface
REQ-001 Parameter: NUM_FLOORS, 8, number of floors served; floor index 3 bits.
REQ-002 Parameter: DOOR_CYCLES, 4, clock cycles the door stays open (range 1..15).
REQ-003 One clock; reset is asynchronous and active-high; ports named clock and reset.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 btn_in  input  8  car-panel button pulses, one bit per floor.
REQ-007 btn_up  input  8  hall up-button pulses, one bit per floor.
REQ-008 btn_down  input  8  hall down-button pulses, one bit per floor.
REQ-009 cur_floor  input  3  current floor from the simulator stage.
REQ-010 open  input  1  floor-match flag from the simulator stage (pending call serviceable at cur_floor in current direction).
REQ-011 call_in / call_up / call_down  output  8 each  latched pending calls, fed to the simulator stage.
REQ-012 direction  output  1  travel direction: 1 = up, 0 = down.
REQ-013 move  output  1  one-cycle pulse requesting a one-floor step in direction.
REQ-014 door_open  output  1  high while the door is open.
REQ-015 state  output  2  current FSM state code.

Function
REQ-016 Call registers: bit f SHALL set on the cycle after btn_*[f] is high and hold until cleared.
REQ-017 On entry to DOOR at floor f: clear call_in[f]; clear call_up[f] if direction=1, else call_down[f].
REQ-018 Simultaneous set and clear of the same bit: clear SHALL win; set and clear of different bits both take effect.
REQ-019 "above" = any call_in|call_up|call_down bit at index > cur_floor; "below" = any at index < cur_floor.
REQ-020 FSM states: IDLE=0, STEP=1, SETTLE=2, DOOR=3.
REQ-021 IDLE: open -> DOOR; else above -> direction=1, STEP; else below -> direction=0, STEP; else stay IDLE.
REQ-022 STEP: move=1 for exactly one cycle, then SETTLE unconditionally.
REQ-023 SETTLE: one cycle for cur_floor to update; then open -> DOOR; else calls ahead in direction -> STEP; else calls behind -> toggle direction, STEP; else IDLE.
REQ-024 DOOR: door_open=1 for exactly DOOR_CYCLES cycles via 4-bit counter loaded on entry; at expiry -> IDLE.
REQ-025 Boundary: move SHALL never be asserted with direction=1 at floor 7 or direction=0 at floor 0.
REQ-026 No pending calls and open=0 in IDLE: outputs hold, move=0, no direction change.
REQ-027 Button pulses in any state SHALL be latched; a press for the current floor during DOOR in the serviced direction is re-latched only after the clearing cycle.
REQ-028 move and door_open SHALL never be high in the same cycle.
REQ-029 Latency button press to first move pulse from IDLE: 3 cycles (latch, IDLE decision, STEP).

Reset
REQ-030 While reset is high: state=IDLE, direction=1, move=0, door_open=0, all call bits 0, door counter 0.
REQ-031 Reset asserted mid-STEP or mid-DOOR SHALL abort immediately with no further move pulse or call clear.

Structure
REQ-032 Shared package holds state encodings, NUM_FLOORS, DOOR_CYCLES default, direction constants UP=1/DOWN=0.
REQ-033 One sub-module call_register: 8-bit set/clear latch with clear-priority, instantiated three times.
REQ-034 FSM, above/below reduction and door counter live in elevator_controller.

Verification
REQ-035 Reset, cur_floor=0, btn_in[3] pulse -> call_in=8'h08, direction=1, move pulse 3 cycles later, STEP->SETTLE alternation until open.
REQ-036 Idle at floor 2, open asserted with call_up[2] set -> DOOR, door_open high 4 cycles, call_up[2] cleared on entry, back to IDLE.
REQ-037 Floor 5 direction=1, only call_down[1] pending, SETTLE -> direction toggles to 0, move resumes downward.
REQ-038 Floor 7 direction=1, no calls above, call_in[4] set -> no up move; direction=0 before next move.
REQ-039 btn_up[2] pulse in the same cycle as DOOR entry at floor 2 going up -> call_up[2]=0 after clear, set again next cycle if pulse repeated.
REQ-040 Reset asserted during DOOR with call_in=8'hFF -> all calls 0, state=IDLE, door_open=0 same cycle.

Source files
------------

// File: rtl/elevator_controller_pkg.sv
// Shared constants and state encoding for the elevator controller.
// Floor count, door dwell default and direction codes live here so every file agrees.
package elevator_controller_pkg;

    localparam int ELEV_NUM_FLOORS  = 8;
    localparam int ELEV_DOOR_CYCLES = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DOOR   = 2'd3
    } state_e;

endpackage

// File: rtl/elevator_controller_call_register.sv
// Per-floor pending-call latch: set bits accumulate, clear bits win over a
// simultaneous set of the same bit.
module call_register #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] set_i,
    input  logic [WIDTH-1:0] clr_i,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = (q_q | set_i) & ~clr_i;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/elevator_controller.sv
// Elevator call scheduler: latches hall/car calls, walks the car one floor per
// STEP/SETTLE pair and holds the door open for DOOR_CYCLES cycles at serviced floors.
module elevator_controller
    import elevator_controller_pkg::*;
#(
    parameter int NUM_FLOORS  = ELEV_NUM_FLOORS,
    parameter int DOOR_CYCLES = ELEV_DOOR_CYCLES
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_FLOORS-1:0]         btn_in,
    input  logic [NUM_FLOORS-1:0]         btn_up,
    input  logic [NUM_FLOORS-1:0]         btn_down,
    input  logic [$clog2(NUM_FLOORS)-1:0] cur_floor,
    input  logic                          open,
    output logic [NUM_FLOORS-1:0]         call_in,
    output logic [NUM_FLOORS-1:0]         call_up,
    output logic [NUM_FLOORS-1:0]         call_down,
    output logic                          direction,
    output logic                          move,
    output logic                          door_open,
    output logic [1:0]                    state
);

    localparam int         TOP_FLOOR = NUM_FLOORS - 1;
    localparam logic [3:0] DOOR_LOAD = 4'(DOOR_CYCLES);

    state_e     state_q, state_d;
    logic       direction_q, direction_d;
    logic [3:0] door_cnt_q, door_cnt_d;

    logic                  enter_door;
    logic                  above, below, ahead, behind, at_limit;
    logic [NUM_FLOORS-1:0] pending, floor_mask;
    logic [NUM_FLOORS-1:0] clr_in, clr_up, clr_down;

    call_register #(.WIDTH(NUM_FLOORS)) u_call_in (
        .clock (clock), .reset (reset), .set_i (btn_in),   .clr_i (clr_in),   .q (call_in)
    );
    call_register #(.WIDTH(NUM_FLOORS)) u_call_up (
        .clock (clock), .reset (reset), .set_i (btn_up),   .clr_i (clr_up),   .q (call_up)
    );
    call_register #(.WIDTH(NUM_FLOORS)) u_call_down (
        .clock (clock), .reset (reset), .set_i (btn_down), .clr_i (clr_down), .q (call_down)
    );

    always_comb begin
        pending = call_in | call_up | call_down;
        above   = 1'b0;
        below   = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(cur_floor)) above = above | pending[i];
            if (i < int'(cur_floor)) below = below | pending[i];
        end
        ahead      = (direction_q == DIR_UP) ? above : below;
        behind     = (direction_q == DIR_UP) ? below : above;
        floor_mask = '0;
        floor_mask[cur_floor] = 1'b1;
        // Last-ditch guard so a stale cur_floor can never drive the car off either end.
        at_limit   = (direction_q == DIR_UP) ? (int'(cur_floor) == TOP_FLOOR)
                                             : (int'(cur_floor) == 0);
    end

    always_comb begin
        state_d     = state_q;
        direction_d = direction_q;
        door_cnt_d  = door_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (open) begin
                    state_d = ST_DOOR;
                end else if (above) begin
                    direction_d = DIR_UP;
                    state_d     = ST_STEP;
                end else if (below) begin
                    direction_d = DIR_DOWN;
                    state_d     = ST_STEP;
                end
            end
            ST_STEP: state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (open) begin
                    state_d = ST_DOOR;
                end else if (ahead) begin
                    state_d = ST_STEP;
                end else if (behind) begin
                    direction_d = ~direction_q;
                    state_d     = ST_STEP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DOOR: begin
                door_cnt_d = (door_cnt_q == 4'd0) ? 4'd0 : door_cnt_q - 4'd1;
                if (door_cnt_q <= 4'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        enter_door = (state_d == ST_DOOR) && (state_q != ST_DOOR);
        if (enter_door) door_cnt_d = DOOR_LOAD;

        // Only the call matching the direction of travel is answered at this stop.
        clr_in   = enter_door ? floor_mask : '0;
        clr_up   = (enter_door && direction_q == DIR_UP)   ? floor_mask : '0;
        clr_down = (enter_door && direction_q == DIR_DOWN) ? floor_mask : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            direction_q <= DIR_UP;
            door_cnt_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            direction_q <= direction_d;
            door_cnt_q  <= door_cnt_d;
        end
    end

    assign direction = direction_q;
    assign move      = (state_q == ST_STEP) && !at_limit;
    assign door_open = (state_q == ST_DOOR);
    assign state     = state_q;

endmodule
